// File: rtl/cpu_fetch_unit.sv
// Instruction-fetch and program-counter block: owns PC, IR and the microstate bit,
// fetches over a req/ready memory handshake and follows the decoder's PC-select commands.
module cpu_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        PS,
    input  logic              IR_L,
    input  logic              NS,
    input  logic [ADDR_W-1:0] Off,
    input  logic [ADDR_W-1:0] Target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       IR,
    output logic              State,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PC_1,
    output logic              stall
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } fsm_e;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // All additions are naturally modulo 2^ADDR_W, so branches and increments wrap both ways.
    function automatic logic [ADDR_W-1:0] next_pc(
        input logic [1:0]        ps,
        input logic [ADDR_W-1:0] pc,
        input logic [ADDR_W-1:0] off,
        input logic [ADDR_W-1:0] target
    );
        logic [ADDR_W-1:0] result;
        case (ps)
            2'b00:   result = pc;
            2'b01:   result = pc + PC_ONE;
            2'b10:   result = pc + off;
            2'b11:   result = target;
            default: result = pc;
        endcase
        return result;
    endfunction

    fsm_e              fsm_q, fsm_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic              state_q, state_d;

    // Next-state selection; decoder inputs only matter in EXEC, memory only in FETCH.
    always_comb begin
        fsm_d   = fsm_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        state_d = state_q;
        case (fsm_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = 1'b0;
                    fsm_d   = ST_EXEC;
                end else begin
                    fsm_d   = ST_FETCH;
                end
            end
            ST_EXEC: begin
                pc_d = next_pc(PS, pc_q, Off, Target);
                if (IR_L) begin
                    state_d = 1'b0;
                    fsm_d   = ST_FETCH;
                end else begin
                    state_d = NS;
                    fsm_d   = ST_EXEC;
                end
            end
            default: begin
                state_d = 1'b0;
                fsm_d   = ST_FETCH;
            end
        endcase
    end

    // State registers; reset abandons any outstanding fetch and restarts at RESET_PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q   <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            state_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            state_q <= state_d;
        end
    end

    assign mem_req  = (fsm_q == ST_FETCH);
    assign stall    = (fsm_q == ST_FETCH);
    assign mem_addr = pc_q;
    assign PC       = pc_q;
    assign PC_1     = pc_q + PC_ONE;
    assign IR       = ir_q;
    assign State    = state_q;

endmodule
